minisys_memio_bridge: RTL and testbench

Parametrised memory/IO bridge between the minisys CPU datapath and its data-side targets. It decodes each CPU load/store into either synchronous data RAM or one of N_IO memory-mapped peripheral channels. It sequences the RAM read latency and peripheral ack handshakes, and stalls the CPU with a ready pulse. Peripherals that never answer time out and raise a sticky error.

---
 rtl/minisys_pkg.sv | 18 +
 rtl/minisys_wait_timer.sv | 28 ++
 rtl/minisys_memio_bridge.sv | 146 ++++++++++++++
 tb/tb_minisys_memio_bridge.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/minisys_pkg.sv
// minisys_pkg: shared state encoding, IO window defaults and width helpers for the memio bridge.
package minisys_pkg;

    typedef enum logic [1:0] {IDLE, MEM, IO, RESP} state_e;

    localparam logic [31:0] IO_BASE_DEF     = 32'hFFFF_FC00;
    localparam int          IO_WIN_LOG2_DEF = 10;
    localparam int          CH_LOG2_DEF     = 4;

    function automatic int ch_idx_w(input int win_log2, input int ch_log2);
        return win_log2 - ch_log2;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/minisys_wait_timer.sv
// minisys_wait_timer: loadable down-counter; done flags the last cycle of a loaded wait.
module minisys_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] cnt_o,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= val_i;
        else if (en_i && cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign cnt_o  = cnt_q;
    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/minisys_memio_bridge.sv
// minisys_memio_bridge: decodes CPU loads/stores to sync RAM or N_IO mapped channels, stalls via a ready pulse.
module minisys_memio_bridge
    import minisys_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                N_IO        = 4,
    parameter logic [ADDR_W-1:0] IO_BASE     = ADDR_W'(IO_BASE_DEF),
    parameter int                IO_WIN_LOG2 = IO_WIN_LOG2_DEF,
    parameter int                CH_LOG2     = CH_LOG2_DEF,
    parameter int                MEM_LAT     = 1,
    parameter int                IO_TIMEOUT  = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   cpu_ready,
    output logic                   err,
    input  logic                   err_clr,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [N_IO-1:0]        io_sel,
    output logic                   io_we,
    output logic [CH_LOG2-1:0]     io_addr,
    output logic [DATA_W-1:0]      io_wdata,
    input  logic [N_IO*DATA_W-1:0] io_rdata,
    input  logic [N_IO-1:0]        io_ack
);

    localparam int CH_W  = ch_idx_w(IO_WIN_LOG2, CH_LOG2);
    localparam int CNT_W = $clog2(max_int(MEM_LAT + 1, IO_TIMEOUT) + 1);

    state_e              state_q, state_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CH_W-1:0]     ch_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d, err_set;

    logic                accept, hit, mapped, ack, t_load, t_done;
    logic [CH_W-1:0]     ch;
    logic [CNT_W-1:0]    t_val, t_cnt;
    logic [N_IO-1:0]     sel;
    logic [DATA_W-1:0]   io_rd;

    assign accept = (state_q == IDLE) && cpu_req;
    assign ch     = cpu_addr[IO_WIN_LOG2-1:CH_LOG2];
    assign hit    = (cpu_addr[ADDR_W-1:IO_WIN_LOG2] == IO_BASE[ADDR_W-1:IO_WIN_LOG2]);
    assign mapped = (32'(ch) < $unsigned(N_IO));

    assign sel = (state_q == IO) ? (N_IO'(1) << ch_q) : '0;
    assign ack = |(io_ack & sel);

    // sel is one-hot in IO, so OR-ing the gated slices picks the addressed channel
    always_comb begin
        io_rd = '0;
        for (int k = 0; k < N_IO; k++)
            io_rd |= sel[k] ? io_rdata[k*DATA_W +: DATA_W] : '0;
    end

    assign t_load = accept;
    assign t_val  = hit ? CNT_W'(IO_TIMEOUT) : CNT_W'(MEM_LAT + 1);

    minisys_wait_timer #(.W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (t_load),
        .en_i   ((state_q == MEM) || (state_q == IO)),
        .val_i  (t_val),
        .cnt_o  (t_cnt),
        .done_o (t_done)
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d = !hit ? MEM : mapped ? IO : RESP;
                    rdata_d = '0;
                    err_set = hit && !mapped;
                end
            end
            MEM: begin
                if (t_done) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : mem_rdata;
                end
            end
            IO: begin
                if (ack || t_done) begin
                    state_d = RESP;
                    rdata_d = (ack && !we_q) ? io_rd : '0;
                    err_set = !ack;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_set || (err_q && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ch_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                ch_q    <= ch;
            end
        end
    end

    assign cpu_ready = (state_q == RESP);
    assign cpu_rdata = cpu_ready ? rdata_q : '0;
    assign err       = err_q;
    assign mem_en    = (state_q == MEM) && (t_cnt == CNT_W'(MEM_LAT + 1));
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = (state_q == MEM) ? addr_q : '0;
    assign mem_wdata = (state_q == MEM) ? wdata_q : '0;
    assign io_sel    = sel;
    assign io_we     = (state_q == IO) && we_q;
    assign io_addr   = (state_q == IO) ? addr_q[CH_LOG2-1:0] : '0;
    assign io_wdata  = (state_q == IO) ? wdata_q : '0;

endmodule

// File: tb/tb_minisys_memio_bridge.sv
// tb_minisys_memio_bridge: transaction-level model of the bridge checked against the DUT every cycle.
module tb_minisys_memio_bridge;

    localparam int T_OUT = 15;
    localparam int M_LAT = 1;

    logic         clk = 1'b0;
    logic         rst, cpu_req, cpu_we, err_clr;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_ready, err, mem_en, mem_we;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [3:0]   io_sel, io_addr, io_ack;
    logic         io_we;
    logic [31:0]  io_wdata;
    logic [127:0] io_rdata;

    minisys_memio_bridge dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .err(err),
        .err_clr(err_clr), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .io_sel(io_sel), .io_we(io_we),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:255];
    logic [31:0] shadow [0:255];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
            else mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    int checks = 0, errors = 0, cyc = 0;
    bit chk_en = 0;

    // current transaction: kind 0 none, 1 RAM, 2 IO channel, 3 unmapped channel
    int          t_kind = 0, t_start = 0, t_E = 0, t_ch = 0;
    bit          t_we, t_ack, t_err, t_ab;
    logic [31:0] t_addr, t_wd, t_rd;
    bit          exp_err = 0;

    int          ready_cnt = 0, ready_cyc = 0, men_cnt = 0, sel_cnt = 0;
    logic [31:0] ready_data;
    logic [3:0]  last_sel, last_io_addr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        int k;
        bit live, in_mem, in_io, e_ready, e_men;
        if (chk_en) begin
            k       = cyc - t_start;
            live    = (t_kind != 0) && !t_ab;
            e_ready = live && (k == t_E);
            e_men   = live && (t_kind == 1) && (k == 1);
            in_mem  = live && (t_kind == 1) && (k >= 1) && (k <= M_LAT + 1);
            in_io   = live && (t_kind == 2) && (k >= 1) && (k < t_E);
            chk("cpu_ready", cpu_ready, e_ready);
            chk("mem_en", mem_en, e_men);
            chk("mem_we", mem_we, e_men && t_we);
            chk("io_sel", io_sel, in_io ? (4'b1 << t_ch) : 4'b0);
            chk("err", err, exp_err);
            if (e_ready) chk("cpu_rdata", cpu_rdata, t_rd);
            if (in_mem) begin
                chk("mem_addr", mem_addr, t_addr);
                chk("mem_wdata", mem_wdata, t_wd);
            end
            if (in_io) begin
                chk("io_addr", io_addr, t_addr[3:0]);
                chk("io_we", io_we, t_we);
                chk("io_wdata", io_wdata, t_wd);
            end
            if (cpu_ready) begin
                ready_cnt++;
                ready_cyc  = cyc;
                ready_data = cpu_rdata;
            end
            if (mem_en) men_cnt++;
            if (io_sel != 0) begin
                sel_cnt++;
                last_sel     = io_sel;
                last_io_addr = io_addr;
            end
        end
    end

    // one clock; err follows set-beats-clear, reset clears it and aborts the transaction
    task automatic step();
        bit s, n, r;
        s = t_err && !t_ab && (cyc - t_start == t_E - 1);
        r = rst;
        n = r ? 1'b0 : s ? 1'b1 : err_clr ? 1'b0 : exp_err;
        @(posedge clk);
        #1;
        cyc++;
        if (r) t_ab = 1;
        exp_err = n;
    endtask

    task automatic do_tx(input bit we, input logic [31:0] addr, input logic [31:0] wd, input int kk,
                         input logic [31:0] ad, input bit hold, input int rst_at, input bit clr0,
                         input bit rclr);
        int ch;
        ch      = int'(addr[9:4]);
        t_kind  = (addr[31:10] != 22'h3FFFFF) ? 1 : (ch < 4) ? 2 : 3;
        t_we    = we;
        t_addr  = addr;
        t_wd    = wd;
        t_ch    = ch;
        t_ack   = (t_kind == 2) && (kk >= 1) && (kk <= T_OUT);
        t_E     = (t_kind == 1) ? M_LAT + 2 : (t_kind == 2) ? (t_ack ? kk + 1 : T_OUT + 1) : 1;
        t_err   = ((t_kind == 2) && !t_ack) || (t_kind == 3);
        t_rd    = (t_kind == 1) ? (we ? 32'h0 : shadow[addr[9:2]]) : (t_ack && !we) ? ad : 32'h0;
        if (t_kind == 1 && we) shadow[addr[9:2]] = wd;
        t_start = cyc;
        t_ab    = 0;
        cpu_req = 1;
        cpu_we  = we;
        cpu_addr = addr;
        cpu_wdata = wd;
        err_clr = clr0;
        for (int k = 1; k <= t_E + 1; k++) begin
            step();
            if (!hold) cpu_req = 0;
            err_clr  = rclr && ($urandom_range(0, 3) == 0);
            io_ack   = 4'($urandom);
            io_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (t_kind == 2) io_ack[ch] = 1'b0;
            if (t_kind == 2 && k == kk) begin
                io_ack[ch] = 1'b1;
                io_rdata[ch*32 +: 32] = ad;
            end
            if (rst_at > 0 && k == rst_at) rst = 1;
            if (rst_at > 0 && k == rst_at + 1) begin
                rst = 0;
                break;
            end
        end
    endtask

    initial begin
        int r0, c0, s0;
        bit hold, rc;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 32'h0;
            shadow[i] = 32'h0;
        end
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; err_clr = 0;
        io_ack = 0; io_rdata = 0; mem_rdata = 0;
        step();
        step();
        rst = 0;
        chk_en = 1;
        step();
        chk("reset_ready", cpu_ready, 0);
        chk("reset_err", err, 0);
        chk("reset_mem_en", mem_en, 0);

        r0 = men_cnt;
        do_tx(1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        chk("store_mem_en_pulses", men_cnt - r0, 1);
        chk("store_ready_lat", ready_cyc - t_start, 3);

        r0 = men_cnt;
        do_tx(0, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0);
        chk("load_mem_en_pulses", men_cnt - r0, 1);
        chk("load_ready_lat", ready_cyc - t_start, 3);
        chk("load_data", ready_data, 32'hDEADBEEF);

        do_tx(0, 32'hFFFF_FC24, 32'h0, 3, 32'h55, 0, 0, 0, 0);
        chk("io_sel_ch2", last_sel, 4'b0100);
        chk("io_addr_ch2", last_io_addr, 4);
        chk("io_ready_lat", ready_cyc - t_start, 4);
        chk("io_data", ready_data, 32'h55);
        chk("io_err", err, 0);

        s0 = sel_cnt;
        do_tx(0, 32'hFFFF_FC10, 32'h0, 0, 0, 0, 0, 0, 0);
        chk("timeout_sel_cycles", sel_cnt - s0, 15);
        chk("timeout_ready_lat", ready_cyc - t_start, 16);
        chk("timeout_data", ready_data, 0);
        chk("timeout_err", err, 1);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("err_clr", err, 0);

        s0 = sel_cnt;
        do_tx(1, 32'hFFFF_FC50, 32'h1234, 0, 0, 0, 0, 1, 0);
        chk("unmapped_ready_lat", ready_cyc - t_start, 1);
        chk("unmapped_sel_cycles", sel_cnt - s0, 0);
        chk("unmapped_set_wins", err, 1);
        err_clr = 1;
        step();
        err_clr = 0;

        r0 = ready_cnt;
        do_tx(0, 32'hFFFF_FC00, 32'h0, 0, 0, 0, 2, 0, 0);
        chk("abort_io_sel", io_sel, 0);
        io_ack = 4'b0001;
        step();
        step();
        io_ack = 0;
        step();
        chk("abort_no_ready", ready_cnt - r0, 0);
        chk("abort_err", err, 0);

        r0 = ready_cnt;
        c0 = 0;
        for (int i = 0; i < 5; i++) begin
            do_tx(0, 32'(i * 4), 32'h0, 0, 0, 1, 0, 0, 0);
            if (i == 0) c0 = ready_cyc;
        end
        cpu_req = 0;
        step();
        chk("hold_ready_count", ready_cnt - r0, 5);
        chk("hold_ready_span", ready_cyc - c0, 4 * (M_LAT + 3));

        for (int n = 0; n < 150; n++) begin
            int sel;
            sel  = $urandom_range(0, 9);
            hold = ($urandom_range(0, 1) == 1);
            rc   = ($urandom_range(0, 3) == 0);
            if (sel < 5)
                a = {22'h0, 8'($urandom), 2'b00};
            else if (sel < 9)
                a = 32'hFFFF_FC00 | 32'($urandom_range(0, 3) << 4) | 32'($urandom_range(0, 15));
            else
                a = 32'hFFFF_FC00 | 32'($urandom_range(4, 63) << 4);
            do_tx($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, T_OUT + 2), $urandom,
                  hold, 0, rc, 1);
            if (!hold && $urandom_range(0, 3) == 0) step();
        end
        cpu_req = 0;
        err_clr = 0;
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
